ball_motion: RTL and testbench

- Per-frame ball physics stage directly upstream of the SRAM frame writer; produces the ball centre coordinates (hor_ball, ver_ball) the writer rasterises into the 100-column x 600-row framebuffer.
- Applies gravity, floor bounce with damping, ceiling and wall clamping, left/right steering and jump from push-buttons.
- Updates exactly once per frame_tick, outside the write window, with both coordinates committed in the same cycle.

---
 rtl/ball_pkg.sv | 26 ++
 rtl/btn_sync.sv | 32 +++
 rtl/ball_motion.sv | 210 +++++++++++++++++++++
 tb/tb_ball_motion.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ball_pkg.sv
// Shared definitions for the ball game pipeline (physics stage and SRAM frame writer).
// Contents:
//   - screen geometry: 100 columns x 600 rows, platform rows 500..519
//   - ball half-sizes: 6 columns, 24 rows
//   - coordinate widths: 7-bit column, 10-bit row
//   - physics FSM state encoding
package ball_pkg;

  localparam int unsigned ScreenCols  = 100;
  localparam int unsigned ScreenRows  = 600;
  localparam int unsigned PlatformTop = 500;
  localparam int unsigned PlatformBot = 519;
  localparam int unsigned BallHalfW   = 6;
  localparam int unsigned BallHalfH   = 24;

  localparam int unsigned HorW = 7;
  localparam int unsigned VerW = 10;

  typedef enum logic [1:0] {
    StIdle,
    StCalcV,
    StCalcH,
    StCommit
  } motion_state_e;

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchroniser with rising-edge detect for an asynchronous push-button.
// Ports:
//   clk   - system clock
//   rst   - asynchronous active-low reset
//   btn   - raw asynchronous button level
//   level - synchronised button level
//   rise  - one-cycle pulse on a 0->1 transition of level
module btn_sync (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic rise
);

  logic [1:0] sync_q;
  logic       prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn};
      prev_q <= sync_q[1];
    end
  end

  assign level = sync_q[1];
  assign rise  = sync_q[1] & ~prev_q;

endmodule

// File: rtl/ball_motion.sv
// Per-frame ball physics: gravity, damped floor bounce, ceiling/wall clamping,
// steering and jump. One update per frame_tick; both coordinates commit together.
// Ports:
//   clk        - 50 MHz system clock
//   rst        - asynchronous active-low reset
//   frame_tick - one-cycle frame pulse (ignored while busy)
//   btn_left   - async button, steer left
//   btn_right  - async button, steer right
//   btn_jump   - async button, jump (edge-triggered, only honoured on the floor)
//   hor_ball   - committed ball centre column
//   ver_ball   - committed ball centre row
//   on_floor   - committed ver_ball sits at FLOOR_Y
//   busy       - update in progress
module ball_motion
  import ball_pkg::*;
#(
  parameter int GRAVITY = 1,
  parameter int VMAX    = 16,
  parameter int JUMP_V  = 14,
  parameter int VSTOP   = 2,
  parameter int HSTEP   = 1,
  parameter int FLOOR_Y = 475,
  parameter int CEIL_Y  = 24,
  parameter int X_MIN   = 6,
  parameter int X_MAX   = 94,
  parameter int X_INIT  = 50,
  parameter int Y_INIT  = 100
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            frame_tick,
  input  logic            btn_left,
  input  logic            btn_right,
  input  logic            btn_jump,
  output logic [HorW-1:0] hor_ball,
  output logic [VerW-1:0] ver_ball,
  output logic            on_floor,
  output logic            busy
);

  localparam logic signed [5:0]  VelGrav = 6'(GRAVITY);
  localparam logic signed [5:0]  VelMax  = 6'(VMAX);
  localparam logic signed [5:0]  VelJump = 6'(JUMP_V);
  localparam logic signed [5:0]  VelStop = 6'(VSTOP);
  localparam logic signed [10:0] YFloor  = 11'(FLOOR_Y);
  localparam logic signed [10:0] YCeil   = 11'(CEIL_Y);
  localparam logic signed [7:0]  XMin    = 8'(X_MIN);
  localparam logic signed [7:0]  XMax    = 8'(X_MAX);
  localparam logic signed [7:0]  XStep   = 8'(HSTEP);

  // Button synchronisers
  logic left_level, left_rise;
  logic right_level, right_rise;
  logic jump_level, jump_rise;

  btn_sync u_sync_left (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_left),
    .level (left_level),
    .rise  (left_rise)
  );

  btn_sync u_sync_right (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_right),
    .level (right_level),
    .rise  (right_rise)
  );

  btn_sync u_sync_jump (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_jump),
    .level (jump_level),
    .rise  (jump_rise)
  );

  // Steering is level-based and jump is edge-based; the other halves are spare.
  logic unused_btn;
  assign unused_btn = left_rise ^ right_rise ^ jump_level;

  // State
  motion_state_e      state_q, state_d;
  logic signed [5:0]  vel_q, vel_d;
  logic signed [10:0] y_w_q, y_w_d;
  logic signed [7:0]  x_w_q, x_w_d;
  logic [HorW-1:0]    hor_q, hor_d;
  logic [VerW-1:0]    ver_q, ver_d;
  logic               floor_q, floor_d;
  logic               jump_pend_q, jump_pend_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      vel_q       <= '0;
      y_w_q       <= '0;
      x_w_q       <= '0;
      hor_q       <= HorW'(X_INIT);
      ver_q       <= VerW'(Y_INIT);
      floor_q     <= 1'b0;
      jump_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      vel_q       <= vel_d;
      y_w_q       <= y_w_d;
      x_w_q       <= x_w_d;
      hor_q       <= hor_d;
      ver_q       <= ver_d;
      floor_q     <= floor_d;
      jump_pend_q <= jump_pend_d;
    end
  end

  // Arithmetic helpers
  logic signed [5:0] vel_inc;
  logic signed [5:0] vel_damp;
  logic signed [7:0] x_base;
  logic signed [7:0] x_move;

  always_comb begin
    vel_inc  = vel_q + VelGrav;
    // Keep three quarters of the impact speed (arithmetic shift on signed vel).
    vel_damp = vel_q - (vel_q >>> 2);
    x_base   = $signed({1'b0, hor_q});
    if (left_level && !right_level) begin
      x_move = x_base - XStep;
    end else if (right_level && !left_level) begin
      x_move = x_base + XStep;
    end else begin
      x_move = x_base;
    end
  end

  always_comb begin
    state_d     = state_q;
    vel_d       = vel_q;
    y_w_d       = y_w_q;
    x_w_d       = x_w_q;
    hor_d       = hor_q;
    ver_d       = ver_q;
    floor_d     = floor_q;
    jump_pend_d = jump_pend_q;

    if (jump_rise) begin
      jump_pend_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (frame_tick) begin
          state_d = StCalcV;
        end
      end

      StCalcV: begin
        if (jump_pend_q && floor_q) begin
          vel_d = -VelJump;
        end else if (vel_inc > VelMax) begin
          vel_d = VelMax;
        end else begin
          vel_d = vel_inc;
        end
        y_w_d       = $signed({1'b0, ver_q}) + $signed({{5{vel_d[5]}}, vel_d});
        // A press latched while airborne is dropped here, not carried to landing.
        jump_pend_d = 1'b0;
        state_d     = StCalcH;
      end

      StCalcH: begin
        if (y_w_q >= YFloor) begin
          y_w_d = YFloor;
          if (vel_damp < VelStop) begin
            vel_d = '0;
          end else begin
            vel_d = -vel_damp;
          end
        end else if (y_w_q <= YCeil) begin
          y_w_d = YCeil;
          vel_d = -vel_q;
        end

        if (x_move < XMin) begin
          x_w_d = XMin;
        end else if (x_move > XMax) begin
          x_w_d = XMax;
        end else begin
          x_w_d = x_move;
        end
        state_d = StCommit;
      end

      StCommit: begin
        hor_d   = HorW'(x_w_q);
        ver_d   = VerW'(y_w_q);
        floor_d = (y_w_q == YFloor);
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  assign hor_ball = hor_q;
  assign ver_ball = ver_q;
  assign on_floor = floor_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_ball_motion.sv
// Self-checking bench for ball_motion: a stimulus table for the first frames, a
// reference model feeding a scoreboard queue for longer sequences, and hand-written
// sequences for landing, rest, jump, wall clamps, double tick and mid-update reset.
module tb_ball_motion;
  import ball_pkg::*;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            frame_tick = 1'b0;
  logic            btn_left = 1'b0;
  logic            btn_right = 1'b0;
  logic            btn_jump = 1'b0;
  logic [HorW-1:0] hor_ball;
  logic [VerW-1:0] ver_ball;
  logic            on_floor;
  logic            busy;

  ball_motion dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_jump   (btn_jump),
    .hor_ball   (hor_ball),
    .ver_ball   (ver_ball),
    .on_floor   (on_floor),
    .busy       (busy)
  );

  always #10 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int m_hor   = 50;
  int m_ver   = 100;
  int m_vel   = 0;
  bit m_floor = 1'b0;
  bit m_jump  = 1'b0;

  // Last committed expectation, used to verify outputs hold while busy
  int last_hor = 50;
  int last_ver = 100;

  typedef struct {
    int hor;
    int ver;
    bit fl;
  } exp_t;

  typedef struct {
    bit l;
    bit r;
    int hor;
    int ver;
    bit fl;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[5];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_hor    = 50;
    m_ver    = 100;
    m_vel    = 0;
    m_floor  = 1'b0;
    m_jump   = 1'b0;
    last_hor = 50;
    last_ver = 100;
  endfunction

  function automatic void model_step(input bit l, input bit r);
    int y;
    int d;
    if (m_jump && m_floor) m_vel = -14;
    else m_vel = (m_vel + 1 > 16) ? 16 : m_vel + 1;
    m_jump = 1'b0;
    y = m_ver + m_vel;
    if (y >= 475) begin
      y = 475;
      d = m_vel - (m_vel >>> 2);
      m_vel = (d < 2) ? 0 : -d;
    end else if (y <= 24) begin
      y = 24;
      m_vel = -m_vel;
    end
    if (l && !r) m_hor = m_hor - 1;
    else if (r && !l) m_hor = m_hor + 1;
    if (m_hor < 6) m_hor = 6;
    if (m_hor > 94) m_hor = 94;
    m_ver   = y;
    m_floor = (y == 475);
  endfunction

  task automatic drive_buttons(input bit l, input bit r);
    @(posedge clk);
    #1;
    btn_left  = l;
    btn_right = r;
    repeat (4) @(posedge clk);
  endtask

  // Pulse frame_tick for 'ticks' cycles, wait for the commit, pop and compare.
  task automatic tick_and_check(input string tag, input int ticks);
    exp_t e;
    int   cnt;
    bit   held;
    @(posedge clk);
    #1 frame_tick = 1'b1;
    repeat (ticks) @(posedge clk);
    #1 frame_tick = 1'b0;
    cnt  = ticks - 1;
    held = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!busy) break;
      cnt++;
      if (int'(hor_ball) != last_hor || int'(ver_ball) != last_ver) held = 1'b0;
    end
    check({tag, "_timeout"}, int'(busy), 0);
    check({tag, "_latency"}, cnt, 3);
    check({tag, "_hold"}, int'(held), 1);
    e = sb_q.pop_front();
    check({tag, "_hor"}, int'(hor_ball), e.hor);
    check({tag, "_ver"}, int'(ver_ball), e.ver);
    check({tag, "_floor"}, int'(on_floor), int'(e.fl));
    last_hor = e.hor;
    last_ver = e.ver;
  endtask

  task automatic model_frame(input bit l, input bit r, input string tag);
    drive_buttons(l, r);
    model_step(l, r);
    sb_q.push_back('{hor: m_hor, ver: m_ver, fl: m_floor});
    tick_and_check(tag, 1);
  endtask

  task automatic pulse_jump();
    @(posedge clk);
    #3 btn_jump = 1'b1;
    repeat (4) @(posedge clk);
    #3 btn_jump = 1'b0;
    repeat (4) @(posedge clk);
    m_jump = 1'b1;
  endtask

  initial begin
    bit ok;
    int n;

    vecs[0] = '{l: 1'b0, r: 1'b0, hor: 50, ver: 101, fl: 1'b0};
    vecs[1] = '{l: 1'b0, r: 1'b1, hor: 51, ver: 103, fl: 1'b0};
    vecs[2] = '{l: 1'b1, r: 1'b0, hor: 50, ver: 106, fl: 1'b0};
    vecs[3] = '{l: 1'b1, r: 1'b1, hor: 50, ver: 110, fl: 1'b0};
    vecs[4] = '{l: 1'b0, r: 1'b0, hor: 50, ver: 115, fl: 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_hor", int'(hor_ball), 50);
    check("rst_ver", int'(ver_ball), 100);
    check("rst_floor", int'(on_floor), 0);
    check("rst_busy", int'(busy), 0);
    @(negedge clk) rst = 1'b1;

    // Table-driven first frames
    for (int i = 0; i < 5; i++) begin
      drive_buttons(vecs[i].l, vecs[i].r);
      model_step(vecs[i].l, vecs[i].r);
      sb_q.push_back('{hor: vecs[i].hor, ver: vecs[i].ver, fl: vecs[i].fl});
      tick_and_check($sformatf("vec%0d", i), 1);
    end

    // Free fall to the floor
    n = 0;
    while (!m_floor && n < 60) begin
      model_frame(1'b0, 1'b0, "fall");
      n++;
    end
    check("land_ver", int'(ver_ball), 475);
    check("land_floor", int'(on_floor), 1);
    model_frame(1'b0, 1'b0, "rebound");
    check("rebound_ver", int'(ver_ball), 464);

    // Bounce until damped to rest, then hold for 10 frames
    n = 0;
    while (!(m_floor && m_vel == 0) && n < 300) begin
      model_frame(1'b0, 1'b0, "bounce");
      n++;
    end
    for (int i = 0; i < 10; i++) model_frame(1'b0, 1'b0, "rest");
    check("rest_ver", int'(ver_ball), 475);
    check("rest_floor", int'(on_floor), 1);

    // Jump from rest, then an airborne jump that must be ignored
    pulse_jump();
    model_frame(1'b0, 1'b0, "jump");
    check("jump_ver", int'(ver_ball), 461);
    check("jump_floor", int'(on_floor), 0);
    pulse_jump();
    model_frame(1'b0, 1'b0, "air_jump");
    check("air_jump_ver", int'(ver_ball), 448);

    // Steering and wall clamps
    for (int i = 0; i < 50; i++) model_frame(1'b0, 1'b1, "right");
    check("right_clamp", int'(hor_ball), 94);
    for (int i = 0; i < 3; i++) model_frame(1'b1, 1'b1, "both");
    check("both_hold", int'(hor_ball), 94);
    for (int i = 0; i < 100; i++) model_frame(1'b1, 1'b0, "left");
    check("left_clamp", int'(hor_ball), 6);

    // Back-to-back ticks: second is ignored, exactly one commit
    drive_buttons(1'b0, 1'b0);
    model_step(1'b0, 1'b0);
    sb_q.push_back('{hor: m_hor, ver: m_ver, fl: m_floor});
    tick_and_check("dbl", 2);
    ok = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (busy || int'(ver_ball) != m_ver || int'(hor_ball) != m_hor) ok = 1'b0;
    end
    check("dbl_single_commit", int'(ok), 1);

    // Reset during CALC_H aborts the update
    @(posedge clk);
    #1 frame_tick = 1'b1;
    @(posedge clk);
    #1 frame_tick = 1'b0;
    @(posedge clk);
    #1;
    check("abort_busy_before", int'(busy), 1);
    rst = 1'b0;
    #1;
    check("abort_hor", int'(hor_ball), 50);
    check("abort_ver", int'(ver_ball), 100);
    check("abort_busy", int'(busy), 0);
    check("abort_floor", int'(on_floor), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
    model_frame(1'b0, 1'b0, "post_reset");
    check("post_reset_ver", int'(ver_ball), 101);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
